// File: rtl/wide_cmp_pkg.sv
// Shared constants, FSM state type and counter sizing helper for the
// iterative wide magnitude comparator.
package wide_cmp_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter is clog2(number of nibble steps), but never narrower than 1 bit.
  function automatic int cnt_width(input int width);
    int n;
    n = width / NIBBLE;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/comparator_4bit.sv
// Cascadable 4-bit unsigned magnitude comparator stage (7485 semantics).
// Purely combinational; the caller owns all registers.
module comparator_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       EqualIn,
  input  logic       GreaterIn,
  input  logic       LessIn,
  output logic       EqualOut,
  output logic       GreaterOut,
  output logic       LessOut
);

  always_comb begin
    EqualOut   = 1'b0;
    GreaterOut = 1'b0;
    LessOut    = 1'b0;
    if (A > B) begin
      GreaterOut = 1'b1;
    end else if (A < B) begin
      LessOut = 1'b1;
    end else begin
      // Equal nibbles defer to whatever the lower-order nibbles decided.
      EqualOut   = EqualIn;
      GreaterOut = GreaterIn;
      LessOut    = LessIn;
    end
  end

endmodule

// File: rtl/wide_comparator_seq.sv
// Iterative WIDTH-bit unsigned comparator: one nibble per cycle, LSB first,
// through a single cascadable 4-bit stage.
module wide_comparator_seq
  import wide_cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             EqualOut,
  output logic             GreaterOut,
  output logic             LessOut
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int CW = cnt_width(WIDTH);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
    $error("wide_comparator_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q;
  logic [CW-1:0]    cnt_q;
  logic             e_q, g_q, l_q;
  logic             busy_q, done_q;
  logic             eq_out_q, gt_out_q, lt_out_q;
  logic             e_d, g_d, l_d;

  comparator_4bit u_stage (
    .A          (sa_q[NIBBLE-1:0]),
    .B          (sb_q[NIBBLE-1:0]),
    .EqualIn    (e_q),
    .GreaterIn  (g_q),
    .LessIn     (l_q),
    .EqualOut   (e_d),
    .GreaterOut (g_d),
    .LessOut    (l_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      cnt_q    <= '0;
      e_q      <= 1'b0;
      g_q      <= 1'b0;
      l_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_out_q <= 1'b0;
      gt_out_q <= 1'b0;
      lt_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sa_q    <= A;
            sb_q    <= B;
            e_q     <= 1'b1;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          e_q   <= e_d;
          g_q   <= g_d;
          l_q   <= l_d;
          sa_q  <= sa_q >> NIBBLE;
          sb_q  <= sb_q >> NIBBLE;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            eq_out_q <= e_d;
            gt_out_q <= g_d;
            lt_out_q <= l_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign EqualOut   = eq_out_q;
  assign GreaterOut = gt_out_q;
  assign LessOut    = lt_out_q;

endmodule

// File: tb/tb_wide_comparator_seq.sv
// Directed + randomized bench for wide_comparator_seq at WIDTH=16 and WIDTH=4,
// checked against plain ==, >, < on the operands.
module tb_wide_comparator_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start16, start4;
  logic [15:0] a16, b16;
  logic [3:0]  a4, b4;
  logic        busy16, done16, eq16, gt16, lt16;
  logic        busy4, done4, eq4, gt4, lt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wide_comparator_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .A(a16), .B(b16),
    .busy(busy16), .done(done16),
    .EqualOut(eq16), .GreaterOut(gt16), .LessOut(lt16)
  );

  wide_comparator_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4),
    .EqualOut(eq4), .GreaterOut(gt4), .LessOut(lt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {Equal, Greater, Less} straight from unsigned arithmetic.
  function automatic logic [2:0] ref_flags(input logic [15:0] a, input logic [15:0] b);
    return {a == b, a > b, a < b};
  endfunction

  function automatic logic [2:0] flags(input int w);
    return (w == 16) ? {eq16, gt16, lt16} : {eq4, gt4, lt4};
  endfunction

  // Start one comparison, wait for done, check latency and result.
  task automatic run_cmp(input int w, input logic [15:0] a, input logic [15:0] b,
                         input string tag);
    int          lat;
    logic [15:0] am, bm;
    logic        dn, bz;
    am = (w == 16) ? a : {12'h0, a[3:0]};
    bm = (w == 16) ? b : {12'h0, b[3:0]};
    if (w == 16) begin a16 = a; b16 = b; start16 = 1'b1; end
    else begin a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1; end
    step();
    start16 = 1'b0;
    start4  = 1'b0;
    a16 = 16'h0; b16 = 16'h0; a4 = 4'h0; b4 = 4'h0;
    bz = (w == 16) ? busy16 : busy4;
    chk({tag, "_busy_after_accept"}, 32'(bz), 32'd1);
    lat = 0;
    dn  = 1'b0;
    while (!dn && lat < 20) begin
      step();
      lat++;
      dn = (w == 16) ? done16 : done4;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(w / 4));
    chk({tag, "_flags"}, 32'(flags(w)), 32'(ref_flags(am, bm)));
    chk({tag, "_onehot"}, 32'($countones(flags(w))), 32'd1);
    bz = (w == 16) ? busy16 : busy4;
    chk({tag, "_busy_at_done"}, 32'(bz), 32'd0);
    $display("%s: W=%0d A=%h B=%h lat=%0d flags(E,G,L)=%b", tag, w, am, bm, lat, flags(w));
  endtask

  initial begin
    int          lat, ndone;
    logic [2:0]  seen;
    logic [15:0] ra, rb;

    reset = 1'b1; start16 = 1'b0; start4 = 1'b0;
    a16 = '0; b16 = '0; a4 = '0; b4 = '0;
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    chk("reset_busy16", 32'(busy16), 32'd0);
    chk("reset_done16", 32'(done16), 32'd0);
    chk("reset_flags16", 32'(flags(16)), 32'd0);
    chk("reset_flags4", 32'(flags(4)), 32'd0);
    $display("reset: busy=%b done=%b flags=%b", busy16, done16, flags(16));

    run_cmp(16, 16'h1234, 16'h1234, "equal");
    run_cmp(16, 16'h8000, 16'h7FFF, "top_override");
    chk("top_override_gt", 32'(gt16), 32'd1);
    run_cmp(16, 16'h00F0, 16'h0100, "less");
    chk("less_lt", 32'(lt16), 32'd1);

    // Back-to-back: start again in the done cycle.
    a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    step();
    start16 = 1'b0; a16 = '0; b16 = '0;
    chk("b2b_done_fell", 32'(done16), 32'd0);
    chk("b2b_busy_rose", 32'(busy16), 32'd1);
    chk("b2b_result_held", 32'(flags(16)), 32'b001);
    lat = 1;
    while (!done16 && lat < 20) begin step(); lat++; end
    chk("b2b_spacing", 32'(lat), 32'd5);
    chk("b2b_flags", 32'(flags(16)), 32'(ref_flags(16'hFFFF, 16'hFFFF)));
    $display("b2b: second done %0d cycles after first, flags=%b", lat, flags(16));

    // start during RUN is ignored.
    a16 = 16'h1111; b16 = 16'h2222; start16 = 1'b1;
    step();
    start16 = 1'b0;
    step();
    a16 = 16'h9999; b16 = 16'h0000; start16 = 1'b1;
    step();
    start16 = 1'b0;
    ndone = 0; seen = 3'b000;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done16) begin ndone++; seen = flags(16); end
    end
    chk("ignored_start_ndone", 32'(ndone), 32'd1);
    chk("ignored_start_flags", 32'(seen), 32'(ref_flags(16'h1111, 16'h2222)));
    $display("ignored_start: dones=%0d flags=%b", ndone, seen);

    // reset during RUN aborts.
    a16 = 16'hABCD; b16 = 16'h1234; start16 = 1'b1;
    step();
    start16 = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done16) ndone++;
      step();
    end
    chk("abort_ndone", 32'(ndone), 32'd0);
    chk("abort_flags", 32'(flags(16)), 32'd0);
    chk("abort_busy", 32'(busy16), 32'd0);
    $display("abort: dones=%0d flags=%b busy=%b", ndone, flags(16), busy16);
    run_cmp(16, 16'h0042, 16'h0041, "after_abort");

    // Random sweep, biased toward equal and near-equal operands.
    for (int i = 0; i < 250; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (16'hF << (4 * $urandom_range(0, 3)));
        default: ;
      endcase
      run_cmp(16, ra, rb, "rand16");
      ra = 16'($urandom_range(0, 15));
      rb = ($urandom_range(0, 2) == 0) ? ra : 16'($urandom_range(0, 15));
      run_cmp(4, ra, rb, "rand4");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
